fetch_prefetch_queue: RTL and testbench

Instruction prefetch stage that sits directly upstream of the Tinker decoder and execute core. It generates sequential PCs and issues 32-bit fetch requests to the unified memory over a valid/ready port. Returned instructions are buffered in order with their PCs and presented to the decoder over a valid/ready output. Branch redirects from control flush the buffer and discard stale in-flight responses.

---
 rtl/tinker_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_prefetch_queue.sv | 122 ++++++++++++
 tb/tb_fetch_prefetch_queue.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_pkg.sv
// Shared fetch-stage types: machine widths, reset PC, fetch FSM states and queue entry layout.
package tinker_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 64'h2000;

   typedef enum logic {
      FETCH,
      DRAIN
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// In-order buffer of fetched {pc, instr} entries; head is combinational from storage.
// Latency: a push is visible at head the cycle after it is written. Flush beats push and pop.
// Backpressure: none internally; the caller guarantees a push never meets a full buffer.
module fetch_fifo
   import tinker_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  fetch_entry_t                 push_dat,
   input  logic                         pop,
   input  logic                         flush,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output fetch_entry_t                 head
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic           pop_ok;
   logic           push_ok;

   assign pop_ok  = pop && (count != '0);
   assign push_ok = push && ((count != CW'(DEPTH)) || pop_ok);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // Storage needs no reset: entries are only observed once count says they were written.
   always_ff @(posedge clk) begin
      if (push_ok && !flush) mem[wr_ptr] <= push_dat;
   end
endmodule

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch: sequential fetch, in-order buffering, redirect flush; FETCH_BYPASS_EN adds response-to-output bypass.
// Latency: first request the cycle after reset release; response reaches out_* next cycle (same cycle with bypass).
// Backpressure: issue stops while buffered + in-flight fetches reach DEPTH; out_ready=0 holds the head.
module fetch_prefetch_queue
   import tinker_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              PC_STEP  = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   output logic            busy
);
   localparam int              CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C = CW'(DEPTH);
   localparam logic [XLEN-1:0] STEP_C  = XLEN'(PC_STEP);

   fetch_state_t    state, state_next;
   logic [XLEN-1:0] fetch_pc, resp_pc;
   logic [CW-1:0]   inflight, inflight_next;
   logic [CW-1:0]   drop_cnt, drop_next;
   logic [CW-1:0]   count;
   logic [CW:0]     occupancy;
   logic            req_fire, resp_ok, resp_keep, bypass, push, pop;
   fetch_entry_t    head, push_dat;

   // Gating with reset keeps the request port quiet while held in reset.
   assign occupancy      = {1'b0, count} + {1'b0, inflight};
   assign imem_req_valid = reset && (state == FETCH) && !redirect_valid && (occupancy < {1'b0, DEPTH_C});
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // A response with nothing outstanding is a protocol error and is ignored outright.
   assign resp_ok       = imem_resp_valid && (inflight != '0);
   assign resp_keep     = resp_ok && (drop_cnt == '0) && !redirect_valid;
   assign inflight_next = inflight + CW'(req_fire) - CW'(resp_ok);
   assign drop_next     = (resp_ok && (drop_cnt != '0)) ? drop_cnt - CW'(1) : drop_cnt;

`ifdef FETCH_BYPASS_EN
   assign bypass = resp_keep && (count == '0);
`else
   assign bypass = 1'b0;
`endif

   assign push     = resp_keep && !(bypass && out_ready);
   assign pop      = out_ready && (count != '0);
   assign push_dat = '{pc: resp_pc, instr: imem_resp_data};
   assign busy     = (state != FETCH) || (inflight != '0);

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .push_dat (push_dat),
      .pop      (pop),
      .flush    (redirect_valid),
      .count    (count),
      .head     (head)
   );

   always_comb begin
      out_valid = 1'b0;
      out_instr = '0;
      out_pc    = '0;
      if (count != '0) begin
         out_valid = 1'b1;
         out_instr = head.instr;
         out_pc    = head.pc;
      end else if (bypass) begin
         out_valid = 1'b1;
         out_instr = imem_resp_data;
         out_pc    = resp_pc;
      end
   end

   always_comb begin
      state_next = state;
      if (redirect_valid) begin
         state_next = (inflight_next != '0) ? DRAIN : FETCH;
      end else if ((state == DRAIN) && (drop_next == '0)) begin
         state_next = FETCH;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= FETCH;
      else        state <= state_next;
   end

   // On redirect everything still outstanding becomes stale and must be dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         resp_pc  <= RESET_PC;
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_next;
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            resp_pc  <= redirect_pc;
            drop_cnt <= inflight_next;
         end else begin
            if (req_fire)  fetch_pc <= fetch_pc + STEP_C;
            if (resp_keep) resp_pc  <= resp_pc + STEP_C;
            drop_cnt <= drop_next;
         end
      end
   end
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue with an in-order 1-cycle memory model.
module tb_fetch_prefetch_queue;
   logic        clk = 1'b0;
   logic        reset;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [63:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_instr;
   logic [63:0] out_pc;
   logic        busy;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] memq[$];
   logic        mem_en = 1'b0;

   always #5 clk = ~clk;

   fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(64'h2000), .PC_STEP(4)) dut (
      .clk             (clk),
      .reset           (reset),
      .redirect_valid  (redirect_valid),
      .redirect_pc     (redirect_pc),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_instr       (out_instr),
      .out_pc          (out_pc),
      .busy            (busy)
   );

   function automatic logic [31:0] word(input logic [63:0] a);
      return {16'hC0DE, a[15:0]};
   endfunction

   // Memory: accepted request answered in the following cycle, in order.
   initial begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      forever begin
         @(negedge clk);
         if (imem_req_valid && imem_req_ready) memq.push_back(imem_req_addr);
         @(posedge clk);
         #2;
         if (mem_en && memq.size() > 0) begin
            imem_resp_valid = 1'b1;
            imem_resp_data  = word(memq.pop_front());
         end else begin
            imem_resp_valid = 1'b0;
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic do_reset(input bit clear_q);
      cyc();
      reset = 1'b0;
      redirect_valid = 1'b0;
      if (clear_q) memq.delete();
      cyc();
      cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1);
   end

   initial begin
      int  n_req;
      bit  found;
      reset = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      imem_req_ready = 1'b1;
      out_ready = 1'b1;
      mem_en = 1'b1;

      // Reset state
      #2;
      chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_instr", 64'(out_instr), 64'd0);
      chk("rst_out_pc", out_pc, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // Streaming with always-ready memory and decoder
      cyc(); reset = 1'b1;
      smp(); chk("s_req_valid0", 64'(imem_req_valid), 64'd1);
             chk("s_req_addr0", imem_req_addr, 64'h2000);
      cyc(); smp();
      chk("s_req_addr1", imem_req_addr, 64'h2004);
      chk("s_out_valid_lat", 64'(out_valid), 64'd0);
      cyc();
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("s_out_valid", 64'(out_valid), 64'd1);
         chk("s_out_pc", out_pc, 64'h2000 + 64'(4 * i));
         chk("s_out_instr", 64'(out_instr), 64'(word(64'h2000 + 64'(4 * i))));
         cyc();
      end

      // Decoder stalled: exactly DEPTH requests, then drain in order
      do_reset(1'b1);
      out_ready = 1'b0;
      cyc(); reset = 1'b1;
      n_req = 0;
      for (int i = 0; i < 8; i++) begin
         smp();
         if (imem_req_valid && imem_req_ready) n_req++;
         cyc();
      end
      smp();
      chk("full_req_count", 64'(n_req), 64'd4);
      chk("full_req_valid", 64'(imem_req_valid), 64'd0);
      chk("full_out_valid", 64'(out_valid), 64'd1);
      cyc(); out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         smp();
         chk("drain_out_pc", out_pc, 64'h2000 + 64'(4 * i));
         chk("drain_out_instr", 64'(out_instr), 64'(word(64'h2000 + 64'(4 * i))));
         cyc();
      end

      // Redirect with two fetches in flight
      do_reset(1'b1);
      mem_en = 1'b0;
      cyc(); reset = 1'b1;
      cyc();
      cyc(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h3000;
      smp(); chk("r2_req_suppressed", 64'(imem_req_valid), 64'd0);
      cyc(); redirect_valid = 1'b0; imem_req_ready = 1'b1; mem_en = 1'b1;
      smp(); chk("r2_busy_drain0", 64'(busy), 64'd1);
             chk("r2_no_req_drain", 64'(imem_req_valid), 64'd0);
      cyc(); smp();
      chk("r2_busy_drain1", 64'(busy), 64'd1);
      chk("r2_no_stale_out", 64'(out_valid), 64'd0);
      cyc(); smp();
      chk("r2_req_valid", 64'(imem_req_valid), 64'd1);
      chk("r2_req_addr", imem_req_addr, 64'h3000);
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
         cyc(); smp();
         if (out_valid) found = 1'b1;
      end
      chk("r2_out_seen", 64'(found), 64'd1);
      chk("r2_first_pc", out_pc, 64'h3000);
      chk("r2_first_instr", 64'(out_instr), 64'hC0DE3000);

      // Redirect coinciding with a response and a pop
      do_reset(1'b1);
      mem_en = 1'b1;
      cyc(); reset = 1'b1;
      cyc();
      cyc(); redirect_valid = 1'b1; redirect_pc = 64'h4000;
      smp(); chk("r1_req_suppressed", 64'(imem_req_valid), 64'd0);
             chk("r1_head_pc", out_pc, 64'h2000);
             chk("r1_resp_present", 64'(imem_resp_valid), 64'd1);
      cyc(); redirect_valid = 1'b0;
      smp(); chk("r1_busy_clear", 64'(busy), 64'd0);
             chk("r1_req_addr", imem_req_addr, 64'h4000);
             chk("r1_out_flushed", 64'(out_valid), 64'd0);
      cyc(); smp();
      chk("r1_no_stale_out", 64'(out_valid), 64'd0);
      cyc(); smp();
      chk("r1_out_valid", 64'(out_valid), 64'd1);
      chk("r1_out_pc", out_pc, 64'h4000);
      chk("r1_out_instr", 64'(out_instr), 64'hC0DE4000);

      // Fetch PC wraps at the top of the address space
      do_reset(1'b1);
      imem_req_ready = 1'b0;
      cyc(); reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
      smp(); chk("w_req_suppressed", 64'(imem_req_valid), 64'd0);
      cyc(); redirect_valid = 1'b0; imem_req_ready = 1'b1;
      smp(); chk("w_req_top", imem_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      cyc(); smp();
      chk("w_req_wrap", imem_req_addr, 64'h0);
      cyc(); smp();
      chk("w_out_pc_top", out_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("w_out_instr_top", 64'(out_instr), 64'hC0DEFFFC);
      cyc(); smp();
      chk("w_out_pc_wrap", out_pc, 64'h0);
      chk("w_out_instr_wrap", 64'(out_instr), 64'hC0DE0000);

      // Asynchronous reset in DRAIN with three in flight
      do_reset(1'b1);
      mem_en = 1'b0;
      cyc(); reset = 1'b1;
      cyc();
      cyc();
      cyc(); imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h5000;
      smp(); chk("ar_req_suppressed", 64'(imem_req_valid), 64'd0);
      cyc(); redirect_valid = 1'b0;
      smp(); chk("ar_busy_drain", 64'(busy), 64'd1);
      cyc(); reset = 1'b0;
      #1;
      chk("ar_req_valid", 64'(imem_req_valid), 64'd0);
      chk("ar_out_valid", 64'(out_valid), 64'd0);
      chk("ar_out_instr", 64'(out_instr), 64'd0);
      chk("ar_out_pc", out_pc, 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      cyc();
      cyc(); reset = 1'b1; mem_en = 1'b1;
      smp(); chk("ar_req_after", 64'(imem_req_valid), 64'd1);
             chk("ar_req_addr", imem_req_addr, 64'h2000);
      for (int r = 0; r < 3; r++) begin
         cyc(); smp();
         chk("ar_stale_out", 64'(out_valid), 64'd0);
         chk("ar_stale_busy", 64'(busy), 64'd0);
      end
      cyc(); imem_req_ready = 1'b1;
      smp(); chk("ar_fire_addr", imem_req_addr, 64'h2000);
      cyc(); smp();
      chk("ar_out_lat", 64'(out_valid), 64'd0);
      cyc(); smp();
      chk("ar_out_valid", 64'(out_valid), 64'd1);
      chk("ar_out_pc", out_pc, 64'h2000);
      chk("ar_out_instr_new", 64'(out_instr), 64'hC0DE2000);
      cyc(); smp();
      chk("ar_out_pc_next", out_pc, 64'h2004);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
